// File: rtl/spi_sched_pkg.sv
// Shared types and constants for the SPI transaction scheduler.
// Holds the FSM state encoding, requester count and the byte-length clamp helper.
package spi_sched_pkg;

  localparam int MAX_BYTES = 4;
  localparam int NREQ      = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_START,
    ST_WAIT,
    ST_HOLD,
    ST_GAP
  } state_t;

  // Requested lengths above MAX_BYTES are clamped rather than rejected.
  function automatic logic [2:0] eff_len(input logic [2:0] len);
    return (len > 3'(MAX_BYTES)) ? 3'(MAX_BYTES) : len;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie the requester not granted last wins.
// The pointer only moves when the caller reports that the grant was accepted.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic last;

  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b1;
    end else if (accept) begin
      last <= grant[1];
    end
  end

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/spi_scheduler.sv
// Schedules multi-byte SPI transactions from two requesters onto a single
// byte engine, framing each with chip-select setup, hold and idle gap.
module spi_scheduler
  import spi_sched_pkg::*;
#(
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int GAP      = 8
) (
  input  logic                       CLOCK_50,
  input  logic                       RESET,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0][2:0]       req_len,
  input  logic [NREQ-1:0][31:0]      req_wdata,
  output logic [NREQ-1:0]            gnt,
  output logic [NREQ-1:0]            done,
  output logic [31:0]                rdata,
  output logic                       busy,
  output logic                       eng_start,
  output logic [7:0]                 eng_tx,
  input  logic                       eng_done,
  input  logic [7:0]                 eng_rx,
  output logic                       SS_N
);

  localparam int CNT_W = 16;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       idx, idx_nxt;
  logic [1:0]       arb_gnt;
  logic             sel;
  logic [2:0]       len_sel;
  logic             accept;
  logic             shift_en;
  logic             fin;
  logic             owner;
  logic             zero_pend;
  logic [31:0]      wdata_q;
  logic [31:0]      rx_shift;

  rr_arbiter2 u_arb (
    .clk    (CLOCK_50),
    .rst    (RESET),
    .req    (req),
    .accept (accept),
    .grant  (arb_gnt)
  );

  assign sel     = arb_gnt[1];
  assign len_sel = req_len[sel];

  // A zero-length grant completes from IDLE without touching SS_N or the engine.
  assign busy = (state != ST_IDLE) || zero_pend;
  assign SS_N = !((state == ST_SETUP) || (state == ST_START) ||
                  (state == ST_WAIT)  || (state == ST_HOLD));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    accept    = 1'b0;
    shift_en  = 1'b0;
    fin       = 1'b0;
    eng_start = 1'b0;
    eng_tx    = 8'h00;
    case (state)
      ST_IDLE: begin
        if (!zero_pend && (|req)) begin
          accept = 1'b1;
          if (len_sel != 3'd0) begin
            state_nxt = ST_SETUP;
            cnt_nxt   = CNT_W'(CS_SETUP - 1);
            idx_nxt   = 2'(eff_len(len_sel) - 3'd1);
          end
        end
      end
      ST_SETUP: begin
        if (cnt == '0) state_nxt = ST_START;
        else           cnt_nxt   = cnt - 1'b1;
      end
      ST_START: begin
        eng_start = 1'b1;
        eng_tx    = wdata_q[{idx, 3'b000} +: 8];
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (eng_done) begin
          shift_en = 1'b1;
          if (idx == 2'd0) begin
            state_nxt = ST_HOLD;
            cnt_nxt   = CNT_W'(CS_HOLD - 1);
          end else begin
            idx_nxt   = idx - 1'b1;
            state_nxt = ST_START;
          end
        end
      end
      ST_HOLD: begin
        if (cnt == '0) begin
          fin       = 1'b1;
          state_nxt = ST_GAP;
          cnt_nxt   = CNT_W'(GAP - 1);
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt == '0) state_nxt = ST_IDLE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      idx       <= '0;
      zero_pend <= 1'b0;
      owner     <= 1'b0;
      gnt       <= '0;
      done      <= '0;
      rdata     <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      gnt       <= accept ? arb_gnt : 2'b00;
      zero_pend <= accept && (len_sel == 3'd0);
      done      <= 2'b00;
      if (accept) begin
        owner <= sel;
      end
      if (zero_pend) begin
        done  <= owner ? 2'b10 : 2'b01;
        rdata <= '0;
      end else if (fin) begin
        done  <= owner ? 2'b10 : 2'b01;
        rdata <= rx_shift;
      end
    end
  end

  // Received bytes enter at the bottom, so the first byte ends highest.
  always_ff @(posedge CLOCK_50) begin
    if (accept) begin
      wdata_q  <= req_wdata[sel];
      rx_shift <= '0;
    end else if (shift_en) begin
      rx_shift <= {rx_shift[23:0], eng_rx};
    end
  end

endmodule

// File: doc/spi_scheduler.md
SPI_SCHEDULER -- requirements
Module: spi_scheduler

Interface
REQ-001 Parameter CS_SETUP, default 4, is the number of cycles SS_N is low before the first byte starts.
REQ-002 Parameter CS_HOLD, default 4, is the number of cycles SS_N stays low after the last byte completes.
REQ-003 Parameter GAP, default 8, is the minimum number of SS_N-high idle cycles between transactions.
REQ-004 CLOCK_50  in  1  sole clock; all logic SHALL be on its rising edge.
REQ-005 RESET  in  1  reset, synchronous, active-high.
REQ-006 req  in  2  level request, one bit per requester (0, 1).
REQ-007 req_len  in  2x3  byte count per requester.
REQ-008 req_wdata  in  2x32  transmit bytes per requester, right-justified.
REQ-009 gnt  out  2  one-hot single-cycle pulse when a request is accepted.
REQ-010 done  out  2  one-hot single-cycle pulse when a transaction completes.
REQ-011 rdata  out  32  received bytes, valid in the done cycle and held until the next done.
REQ-012 busy  out  1  high from the gnt cycle through the last GAP cycle.
REQ-013 eng_start  out  1  single-cycle pulse that starts one byte on the byte engine.
REQ-014 eng_tx  out  8  byte to send, valid in the eng_start cycle.
REQ-015 eng_done  in  1  single-cycle pulse from the engine when a byte completes.
REQ-016 eng_rx  in  8  received byte, valid with eng_done.
REQ-017 SS_N  out  1  active-low slave select.

Function
REQ-018 States: IDLE, SETUP, START, WAIT, HOLD, GAP.
REQ-019 Arbitration is sampled in IDLE only and is round-robin: on simultaneous requests, the requester not granted last wins.
REQ-020 When req is seen in IDLE at edge N, the following SHALL occur in cycle N+1: gnt pulses, SS_N goes low, busy goes high, len and wdata are latched, and the state becomes SETUP.
REQ-021 Effective length L = min(req_len, 4).
REQ-022 When req_len = 0, the block SHALL pulse gnt, then pulse done on the next cycle with rdata = 0, with no SS_N or engine activity and no GAP.
REQ-023 SETUP SHALL last exactly CS_SETUP cycles, then enter START.
REQ-024 START SHALL pulse eng_start for one cycle with eng_tx = byte k, then enter WAIT.
REQ-025 Bytes are sent from byte L-1 (wdata[8L-1:8L-8]) down to byte 0.
REQ-026 In WAIT, on eng_done the block SHALL shift eng_rx into a right-justified register (first byte ends in the highest used byte; upper bytes are 0).
REQ-027 After eng_done in WAIT, the block SHALL return to START for the next byte on the next cycle, or enter HOLD after byte 0.
REQ-028 eng_done outside WAIT SHALL be ignored.
REQ-029 HOLD SHALL last CS_HOLD cycles with SS_N low.
REQ-030 On HOLD exit, SS_N rises and done pulses for the granted requester in the same cycle, with rdata updated, then the state enters GAP.
REQ-031 GAP SHALL last GAP cycles with SS_N high, then return to IDLE.
REQ-032 busy SHALL fall on entering IDLE.
REQ-033 A req deasserted mid-transaction SHALL NOT abort the transaction.
REQ-034 A req still high at IDLE SHALL be treated as a new request.
REQ-035 At most one eng_start SHALL be outstanding at any time.

Reset
REQ-036 While RESET is high at an edge, the following SHALL hold on the next cycle: state IDLE, SS_N = 1, gnt = 0, done = 0, eng_start = 0, eng_tx = 0, rdata = 0, busy = 0, round-robin pointer = 1 (so requester 0 wins first).
REQ-037 Reset mid-transaction SHALL produce no done pulse and SHALL discard partial rx data.

Structure
REQ-038 Package spi_sched_pkg SHALL hold the state enum, MAX_BYTES = 4, and the requester count NREQ = 2.
REQ-039 Sub-module rr_arbiter2 SHALL provide the 2-way round-robin grant with a pointer update on accept.

Verification
REQ-040 Single request: req[0] = 1, len = 2, wdata = 0x0000A55A, engine echoes rx = ~tx → eng_tx sequence A5, 5A; done[0]; rdata = 0x00005AA5; SS_N low for 4 + bytes + 4 cycles.
REQ-041 Simultaneous request: req = 2'b11 after reset → gnt = 01 first; after GAP, gnt = 10; then gnt = 01 again if both are held.
REQ-042 len = 0 → gnt pulse, done pulse one cycle later, SS_N never low, rdata = 0.
REQ-043 len = 7 with wdata = 0x11223344 → exactly 4 eng_start pulses, eng_tx = 11, 22, 33, 44.
REQ-044 RESET asserted during WAIT → next cycle SS_N = 1, busy = 0, no done pulse; a fresh request then completes normally.
REQ-045 Spurious eng_done during SETUP or GAP → ignored; byte count and rdata are unaffected.
